// File: rtl/alu_1b_pkg.sv
// Shared op encodings for the 1-bit ALU slice.
// Latency: n/a (package). Backpressure: n/a.
// Optional XOR/NOR codes are only decoded when ALU_1B_EXT_LOGIC_EN is defined.
package alu_1b_pkg;

    typedef enum logic [2:0] {
        OP_AND       = 3'b000,
        OP_XOR       = 3'b001,
        OP_OR        = 3'b010,
        OP_NOR       = 3'b011,
        OP_ADD       = 3'b100,
        OP_SUB       = 3'b101,
        OP_PASS_LESS = 3'b110,
        OP_SLT       = 3'b111
    } op_t;

endpackage

// File: rtl/alu_1b_addsub.sv
// Full adder / full subtractor bit shared by ADD, SUB and SLT.
// Latency: combinational. Backpressure: none.
// sub=1 turns cout into a borrow-out (A - B - Ci < 0).
module alu_1b_addsub (
    input  logic A,
    input  logic B,
    input  logic Ci,
    input  logic sub,
    output logic sum,
    output logic cout
);

    logic carry_out;
    logic borrow_out;

    assign carry_out  = (A & B) | (A & Ci) | (B & Ci);
    assign borrow_out = (~A & B) | (~A & Ci) | (B & Ci);

    assign sum  = A ^ B ^ Ci;
    assign cout = sub ? borrow_out : carry_out;

endmodule

// File: rtl/alu_1b.sv
// 1-bit ALU slice with registered R/Co; XOR/NOR enabled by ALU_1B_EXT_LOGIC_EN.
// Latency: 1 cycle from inputs to R/Co. Backpressure: none, accepts every cycle.
// Synchronous active-high Reset clears both outputs and wins over the result.
module alu_1b
    import alu_1b_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       A,
    input  logic       B,
    input  logic       Ci,
    input  logic [2:0] Op,
    input  logic       Less,
    output logic       R,
    output logic       Co
);

    logic r_d, r_q;
    logic co_d, co_q;
    logic as_sub;
    logic as_sum;
    logic as_cout;

    // SUB and SLT both use the borrow form; only ADD uses carry.
    assign as_sub = (op_t'(Op) != OP_ADD);

    alu_1b_addsub u_addsub (
        .A    (A),
        .B    (B),
        .Ci   (Ci),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        r_d  = 1'b0;
        co_d = 1'b0;
        case (op_t'(Op))
            OP_AND:       r_d = A & B;
            OP_OR:        r_d = A | B;
            OP_ADD,
            OP_SUB,
            OP_SLT: begin
                r_d  = as_sum;
                co_d = as_cout;
            end
            OP_PASS_LESS: r_d = Less;
`ifdef ALU_1B_EXT_LOGIC_EN
            OP_XOR:       r_d = A ^ B;
            OP_NOR:       r_d = ~(A | B);
`endif
            default: begin
                r_d  = 1'b0;
                co_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_q  <= 1'b0;
            co_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            co_q <= co_d;
        end
    end

    assign R  = r_q;
    assign Co = co_q;

endmodule

// File: tb/tb_alu_1b.sv
// Bench for alu_1b: arithmetic reference model checked every cycle, plus literal vectors.
module tb_alu_1b;

    logic       CLK;
    logic       Reset;
    logic       A;
    logic       B;
    logic       Ci;
    logic [2:0] Op;
    logic       Less;
    logic       R;
    logic       Co;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    alu_1b dut (
        .CLK   (CLK),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .Op    (Op),
        .Less  (Less),
        .R     (R),
        .Co    (Co)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Returns {Co, R} from plain integer arithmetic.
    function automatic logic [1:0] model(input logic rst, input logic a, input logic b,
                                         input logic ci, input logic [2:0] op, input logic less);
        int s;
        logic r, co;
        r = 1'b0;
        co = 1'b0;
        if (!rst) begin
            case (op)
                3'd0: r = a & b;
                3'd2: r = a | b;
                3'd4: begin
                    s  = int'(a) + int'(b) + int'(ci);
                    r  = (s % 2) == 1;
                    co = s >= 2;
                end
                3'd5, 3'd7: begin
                    s  = int'(a) - int'(b) - int'(ci);
                    r  = (s & 1) != 0;
                    co = s < 0;
                end
                3'd6: r = less;
`ifdef ALU_1B_EXT_LOGIC_EN
                3'd1: r = a ^ b;
                3'd3: r = ~(a | b);
`endif
                default: begin
                    r  = 1'b0;
                    co = 1'b0;
                end
            endcase
        end
        return {co, r};
    endfunction

    // Per-cycle compare against the model.
    always @(posedge CLK) begin
        logic [1:0] exp;
        exp = model(Reset, A, B, Ci, Op, Less);
        #1;
        checks++;
        if ({Co, R} !== exp) begin
            errors++;
            $display("FAIL model t=%0t op=%0d a=%0b b=%0b ci=%0b less=%0b rst=%0b: got R=%0b Co=%0b want R=%0b Co=%0b",
                     $time, Op, A, B, Ci, Less, Reset, R, Co, exp[0], exp[1]);
        end
        started = 1;
    end

    task automatic step(input logic rst, input logic a, input logic b, input logic ci,
                        input logic [2:0] op, input logic less,
                        input logic exp_r, input logic exp_co, input string name);
        Reset = rst; A = a; B = b; Ci = ci; Op = op; Less = less;
        @(posedge CLK);
        #1;
        checks++;
        if (R !== exp_r || Co !== exp_co) begin
            errors++;
            $display("FAIL %s: got R=%0b Co=%0b want R=%0b Co=%0b", name, R, Co, exp_r, exp_co);
        end
    endtask

    logic ext_xor_exp;

    initial begin
`ifdef ALU_1B_EXT_LOGIC_EN
        ext_xor_exp = 1'b1;
`else
        ext_xor_exp = 1'b0;
`endif
        Reset = 1'b1; A = 1'b1; B = 1'b1; Ci = 1'b0; Op = 3'b100; Less = 1'b0;
        #2;
        step(1, 1, 1, 1, 3'b100, 0, 0, 0, "reset");
        step(0, 0, 1, 0, 3'b000, 0, 0, 0, "and01");
        step(0, 1, 1, 0, 3'b000, 0, 1, 0, "and11");
        step(0, 1, 1, 0, 3'b010, 0, 1, 0, "or11");
        step(0, 1, 0, 0, 3'b010, 0, 1, 0, "or10");
        step(0, 0, 0, 0, 3'b010, 0, 0, 0, "or00");
        step(0, 0, 1, 0, 3'b100, 0, 1, 0, "add010");
        step(0, 1, 1, 0, 3'b100, 0, 0, 1, "add110");
        step(0, 1, 1, 1, 3'b100, 0, 1, 1, "add111");
        step(0, 1, 0, 0, 3'b101, 0, 1, 0, "sub100");
        step(0, 1, 1, 0, 3'b101, 0, 0, 0, "sub110");
        step(0, 0, 1, 0, 3'b101, 0, 1, 1, "sub010");
        step(0, 1, 0, 0, 3'b111, 0, 1, 0, "slt1000");
        step(0, 0, 0, 0, 3'b111, 0, 0, 0, "slt0000");
        step(0, 0, 0, 1, 3'b111, 1, 1, 1, "slt_borrow");
        step(0, 0, 0, 0, 3'b110, 1, 1, 0, "pass_less");
        step(0, 1, 0, 0, 3'b001, 0, ext_xor_exp, 0, "xor10");
        step(1, 1, 1, 1, 3'b100, 1, 0, 0, "reset_prio");
        step(0, 1, 1, 1, 3'b100, 0, 1, 1, "resume");

        for (int i = 0; i < 400; i++) begin
            Reset = ($urandom_range(15) == 0);
            A     = 1'($urandom_range(1));
            B     = 1'($urandom_range(1));
            Ci    = 1'($urandom_range(1));
            Op    = 3'($urandom_range(7));
            Less  = 1'($urandom_range(1));
            @(posedge CLK);
            #2;
        end

        @(posedge CLK);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_1b.md
ALU_1B -- requirements
Module: alu_1b

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have port A, input, 1 bit: operand A bit.
REQ-004 SHALL have port B, input, 1 bit: operand B bit.
REQ-005 SHALL have port Ci, input, 1 bit: carry-in for ADD; borrow-in for SUB and SLT.
REQ-006 SHALL have port Op, input, 3 bits: operation select.
REQ-007 SHALL have port Less, input, 1 bit: value forwarded by the PASS_LESS operation.
REQ-008 SHALL have port R, output, 1 bit: registered result bit.
REQ-009 SHALL have port Co, output, 1 bit: registered carry-out or borrow-out.

Function
REQ-010 SHALL compute next-R and next-Co combinationally from A, B, Ci, Op, Less, and register both on each rising CLK; latency is exactly 1 cycle, with no enable or handshake.
REQ-011 SHALL decode Op 000 AND: R = A & B, Co = 0.
REQ-012 SHALL decode Op 010 OR: R = A | B, Co = 0.
REQ-013 SHALL decode Op 100 ADD: R = A ^ B ^ Ci, Co = (A&B) | (A&Ci) | (B&Ci).
REQ-014 SHALL decode Op 101 SUB (borrow form): R = A ^ B ^ Ci, Co = (~A&B) | (~A&Ci) | (B&Ci).
REQ-015 SHALL decode Op 111 SLT, the set slice: R = SUB difference bit A ^ B ^ Ci, Co = SUB borrow-out; Less is ignored.
REQ-016 SHALL decode Op 110 PASS_LESS, the non-set slices of a wide SLT: R = Less, Co = 0.
REQ-017 SHALL decode Op 001 XOR (R = A ^ B) and Op 011 NOR (R = ~(A | B)), with Co = 0, when REQ-024 is enabled.
REQ-018 SHALL leave no Op value undefined: any code not enabled SHALL give R = 0, Co = 0.
REQ-019 SHALL use a new Op on the edge where it is sampled; there is no carried state between cycles other than the R and Co registers.

Reset
REQ-020 SHALL load R = 0 and Co = 0 on any rising CLK where Reset = 1, regardless of the other inputs.
REQ-021 SHALL give Reset priority over the computed result when both occur on the same edge.
REQ-022 SHALL resume normal operation on the first rising CLK with Reset = 0.
REQ-023 SHALL have no asynchronous paths; outputs are undefined only before the first clock edge.

Configuration
REQ-024 SHALL compile XOR (001) and NOR (011) in only when macro ALU_1B_EXT_LOGIC_EN is defined; without the macro, 001 and 011 SHALL yield R = 0, Co = 0 per REQ-018.
REQ-025 SHALL leave ports and the behaviour of all other Op codes unchanged by the macro.

Structure
REQ-026 SHALL place the Op encodings in shared package alu_1b_pkg, as a 3-bit enum typedef named op_t: AND=000, XOR=001, OR=010, NOR=011, ADD=100, SUB=101, PASS_LESS=110, SLT=111.
REQ-027 SHALL implement add/subtract in one sub-module alu_1b_addsub (inputs A, B, Ci, sub; outputs sum, cout) shared by ADD, SUB and SLT.
REQ-028 SHALL keep the output register stage in alu_1b itself.

Verification
REQ-029 SHALL check: Reset=1 for 1 edge with A=1, B=1, Op=100 -> R=0, Co=0 after the edge.
REQ-030 SHALL check: A=0, B=1, Op=000 -> R=0; then A=1, B=1, Op=000 -> R=1, each checked 1 edge later.
REQ-031 SHALL check: Op=010 with (A,B) = (1,1), (1,0), (0,0) -> R = 1, 1, 0.
REQ-032 SHALL check: Op=100 with (A,B,Ci) = (0,1,0), (1,1,0), (1,1,1) -> (R,Co) = (1,0), (0,1), (1,1).
REQ-033 SHALL check: Op=101 with (A,B,Ci) = (1,0,0), (1,1,0) -> (R,Co) = (1,0), (0,0); and Op=111 with (A,B,Ci,Less) = (1,0,0,0) -> R=1, (0,0,0,0) -> R=0.
REQ-034 SHALL check: Op=110 with Less=1 -> R=1, Co=0; and Op=001 with A=1, B=0 -> R=1 with ALU_1B_EXT_LOGIC_EN, R=0 without it.
